// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the ROM, and fills the IF/ID register.
// Also counts the instructions captured into IF/ID.
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | just out of reset, ROM disabled, PC = RESET_PC
// RUN   | fetching, ROM enabled every cycle
module if_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [INST_W-1:0] inst_i,
    output logic              ce,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [31:0]       fetch_cnt
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [INST_W-1:0] id_inst_q, id_inst_d;
    logic [31:0]       fetch_cnt_q, fetch_cnt_d;
    logic              capture;

    // Upper stall bits belong to later stages; low address bits are forced to word alignment.
    logic unused_inputs;
    assign unused_inputs = ^{stall[5:2], new_pc[1:0], branch_target[1:0]};

    assign capture = !flush && !stall[1] && !stall[0] && (state_q == RUN);

    always_comb begin
        state_d     = RUN;
        pc_d        = pc_q;
        id_pc_d     = id_pc_q;
        id_inst_d   = id_inst_q;
        fetch_cnt_d = fetch_cnt_q;

        if (state_q == RUN) begin
            if (flush) begin
                pc_d = {new_pc[ADDR_W-1:2], 2'b00};
            end else if (!stall[0]) begin
                if (branch_flag) begin
                    pc_d = {branch_target[ADDR_W-1:2], 2'b00};
                end else begin
                    pc_d = pc_q + ADDR_W'(4);
                end
            end
        end

        if (flush || (!stall[1] && (stall[0] || (state_q == IDLE)))) begin
            id_pc_d   = '0;
            id_inst_d = '0;
        end else if (capture) begin
            id_pc_d     = pc_q;
            id_inst_d   = inst_i;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            id_pc_q     <= '0;
            id_inst_q   <= '0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign ce        = (state_q == RUN);
    assign pc        = pc_q;
    assign id_pc     = id_pc_q;
    assign id_inst   = id_inst_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: startup, stalls, branch, flush, PC wrap, mid-run reset.
// The ROM is modelled here; expected values are hand-computed constants.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic [31:0] inst_i;
    logic        ce;
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [31:0] fetch_cnt;

    int n_total;
    int n_pass;

    if_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .branch_flag  (branch_flag),
        .branch_target(branch_target),
        .inst_i       (inst_i),
        .ce           (ce),
        .pc           (pc),
        .id_pc        (id_pc),
        .id_inst      (id_inst),
        .fetch_cnt    (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Words 0..3 hold the given program; everything else reads back A000 plus the low address half.
    always_comb begin
        case (pc)
            32'h0:   inst_i = 32'h3401_1100;
            32'h4:   inst_i = 32'h3402_0020;
            32'h8:   inst_i = 32'h3403_FF00;
            32'hC:   inst_i = 32'h3404_FFFF;
            default: inst_i = {16'hA000, pc[15:0]};
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic exp_ce, input logic [31:0] exp_pc,
                           input logic [31:0] exp_idpc, input logic [31:0] exp_inst,
                           input logic [31:0] exp_cnt);
        chk({tag, ".ce"},      {31'd0, ce}, {31'd0, exp_ce});
        chk({tag, ".pc"},      pc,          exp_pc);
        chk({tag, ".id_pc"},   id_pc,       exp_idpc);
        chk({tag, ".id_inst"}, id_inst,     exp_inst);
        chk({tag, ".cnt"},     fetch_cnt,   exp_cnt);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total       = 0;
        n_pass        = 0;
        rst           = 1'b1;
        stall         = 6'b0;
        flush         = 1'b0;
        new_pc        = 32'h0;
        branch_flag   = 1'b0;
        branch_target = 32'h0;

        #2;
        chk_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 32'd0);
        rst = 1'b0;

        step(); chk_all("e1", 1'b1, 32'h0, 32'h0, 32'h0, 32'd0);
        step(); chk_all("e2", 1'b1, 32'h4, 32'h0, 32'h3401_1100, 32'd1);
        step(); chk_all("e3", 1'b1, 32'h8, 32'h4, 32'h3402_0020, 32'd2);
        step(); chk_all("e4", 1'b1, 32'hC, 32'h8, 32'h3403_FF00, 32'd3);

        // Full stall for two cycles at pc=0xC.
        stall = 6'b000011;
        step(); chk_all("stall2_a", 1'b1, 32'hC, 32'h8, 32'h3403_FF00, 32'd3);
        step(); chk_all("stall2_b", 1'b1, 32'hC, 32'h8, 32'h3403_FF00, 32'd3);
        stall = 6'b000000;
        step(); chk_all("stall2_resume", 1'b1, 32'h10, 32'hC, 32'h3404_FFFF, 32'd4);

        // PC-only stall inserts one bubble.
        stall = 6'b000001;
        step(); chk_all("bubble", 1'b1, 32'h10, 32'h0, 32'h0, 32'd4);
        stall = 6'b000000;
        step(); chk_all("bubble_resume", 1'b1, 32'h14, 32'h10, 32'hA000_0010, 32'd5);

        // Branch with misaligned target; delay slot is captured normally.
        branch_flag   = 1'b1;
        branch_target = 32'h0000_0043;
        step(); chk_all("br_slot", 1'b1, 32'h40, 32'h14, 32'hA000_0014, 32'd6);
        branch_flag = 1'b0;
        step(); chk_all("br_target", 1'b1, 32'h44, 32'h40, 32'hA000_0040, 32'd7);

        // Flush beats branch and stall together.
        flush         = 1'b1;
        new_pc        = 32'h0000_0022;
        branch_flag   = 1'b1;
        branch_target = 32'h0000_0080;
        stall         = 6'b000011;
        step(); chk_all("flush", 1'b1, 32'h20, 32'h0, 32'h0, 32'd7);
        flush       = 1'b0;
        branch_flag = 1'b0;
        stall       = 6'b000000;
        step(); chk_all("flush_resume", 1'b1, 32'h24, 32'h20, 32'hA000_0020, 32'd8);

        // PC wrap from the top of the address space.
        branch_flag   = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step(); chk_all("br_top", 1'b1, 32'hFFFF_FFFC, 32'h24, 32'hA000_0024, 32'd9);
        branch_flag = 1'b0;
        step(); chk_all("wrap", 1'b1, 32'h0, 32'hFFFF_FFFC, 32'hA000_FFFC, 32'd10);

        // Illegal combination from control: PC advances while IF/ID holds.
        stall = 6'b000010;
        $display("note: driving illegal stall=000010 (PC advances, IF/ID holds, fetch lost)");
        step(); chk_all("illegal", 1'b1, 32'h4, 32'hFFFF_FFFC, 32'hA000_FFFC, 32'd10);
        stall = 6'b000000;

        // Asynchronous reset between edges.
        rst = 1'b1;
        #2;
        chk_all("async_rst", 1'b0, 32'h0, 32'h0, 32'h0, 32'd0);
        step(); chk_all("rst_held", 1'b0, 32'h0, 32'h0, 32'h0, 32'd0);
        rst = 1'b0;
        step(); chk_all("r_e1", 1'b1, 32'h0, 32'h0, 32'h0, 32'd0);
        step(); chk_all("r_e2", 1'b1, 32'h4, 32'h0, 32'h3401_1100, 32'd1);
        step(); chk_all("r_e3", 1'b1, 32'h8, 32'h4, 32'h3402_0020, 32'd2);
        step(); chk_all("r_e4", 1'b1, 32'hC, 32'h8, 32'h3403_FF00, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
